seg7_lut: RTL and testbench
===========================

# seg7_lut

Hex-digit to seven-segment decoder with a registered output, used by `Core` to show nibbles such as `pc[3:0]` on the board displays. It maps a 4-bit value (0–F) to a 7-bit segment pattern. Blank and lamp-test controls are included, and an optional blink function can be compiled in. One instance drives one digit.

## Interface
Parameters:
- `ACTIVE_LOW`, default 1. When 1, a segment is lit by driving 0. When 0, all output polarities are inverted.
- `BLINK_DIV`, default 25_000_000. Number of clock cycles per blink half-period. Legal range is 2 to 2^26−1.

Ports:
- `clk`  input  1  System clock. Everything is on the rising edge.
- `reset`  input  1  Reset. Synchronous, active-high.
- `iDIG`  input  4  Hex digit to display.
- `iBLANK`  input  1  When 1, all segments are dark.
- `iLT`  input  1  Lamp test. When 1, all segments are lit.
- `iBLINK`  input  1  Blink request. Ignored when blink is compiled out.
- `oSEG`  output  7  Registered segment pattern. Bit 0 = a, 1 = b, 2 = c, 3 = d, 4 = e, 5 = f, 6 = g.

## Operation
- Active-low codes (used when `ACTIVE_LOW`=1), for digits 0–F:
  - 0: 40, 1: 79, 2: 24, 3: 30
  - 4: 19, 5: 12, 6: 02, 7: 78
  - 8: 00, 9: 18, A: 08, b: 03
  - C: 46, d: 21, E: 06, F: 0E
- When `ACTIVE_LOW`=0, every code is bitwise inverted, including the dark (7F) and all-lit (00) patterns.
- Priority, highest first:
  1. `reset`: output dark.
  2. `iLT`: all lit (00 active-low).
  3. `iBLANK`: dark (7F active-low).
  4. Blink-off phase: dark, only when compiled in and `iBLINK`=1.
  5. Decoded `iDIG`.
- All 16 input codes are valid. There is no illegal-input case.
- Blink logic (compiled in only):
  - 26-bit counter `cnt` counts 0 .. `BLINK_DIV`−1, then wraps to 0.
  - 1-bit `phase` toggles on each wrap. `phase`=1 means on.
  - The counter runs freely, independent of `iBLINK`.
  - When `iBLINK`=1 and `phase`=0, the output is dark.
  - When `iBLINK`=0, `phase` has no effect.

## Timing
- Latency is one cycle: `oSEG` after edge N reflects `iDIG`, `iBLANK`, `iLT`, `iBLINK` and `phase` as sampled at edge N.
- Reset values:
  - `oSEG` = dark (7F when `ACTIVE_LOW`=1, 00 otherwise).
  - `cnt` = 0, `phase` = 1.
- Reset asserted mid-operation: on the next edge the output goes dark and the blink timebase restarts. Decoding resumes on the first edge with `reset` low.
- The output is a flop, so it is glitch-free. Input changes between edges have no effect.
- Blink wrap: when `cnt` = `BLINK_DIV`−1 at an edge, `cnt` goes to 0 and `phase` flips at that same edge. The output register samples the old `phase` at that edge, so the visible effect appears one edge later. Each half-period is exactly `BLINK_DIV` cycles.
- If `iLT` and `iBLANK` are both 1, the output is all lit.

## Configuration
- Macro `SEG7_LUT_BLINK_EN`.
- Defined: the counter, `phase` and blink gating are built. `iBLINK`=1 produces a square-wave blink with period 2×`BLINK_DIV` cycles.
- Undefined: no counter or phase registers exist. `iBLINK` is ignored and left unconnected internally. The output depends only on `iDIG`, `iBLANK` and `iLT`. The port list stays identical in both builds.

## Test plan
- Reset held 3 cycles with `iDIG`=8 -> `oSEG`=7F throughout. After release, one edge later `oSEG`=00.
- Sweep `iDIG` 0..F, one value per cycle -> `oSEG` follows the table one cycle later (e.g. 0→40, 5→12, A→08, F→0E).
- `iDIG`=3 with `iBLANK`=1 -> 7F. Add `iLT`=1 -> 00. Drop both -> 30.
- `ACTIVE_LOW`=0, `iDIG`=1 -> 06. Reset -> 00.
- With `SEG7_LUT_BLINK_EN`, `BLINK_DIV`=4, `iBLINK`=1, `iDIG`=0 -> after reset, `oSEG` shows 40 for 4 cycles, 7F for 4 cycles, and repeats. `iLT`=1 during an off phase -> 00.
- Without the macro, same stimulus -> `oSEG` stays 40 steadily.

Source files
------------

// File: rtl/seg7_lut.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_lut                                                     |
// | Description : Hex nibble to seven-segment decoder with registered output,  |
// |               lamp test, blank and optional blink (SEG7_LUT_BLINK_EN).     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module seg7_lut #(
   parameter bit          ACTIVE_LOW = 1'b1,
   parameter int unsigned BLINK_DIV  = 25_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] iDIG,
   input  logic       iBLANK,
   input  logic       iLT,
   input  logic       iBLINK,
   output logic [6:0] oSEG
);

   localparam logic [6:0]  c_DARK_AL  = 7'h7F;
   localparam logic [6:0]  c_LIT_AL   = 7'h00;
   localparam logic [6:0]  c_DARK_OUT = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [25:0] c_CNT_MAX  = 26'(BLINK_DIV - 1);

   logic [6:0] w_digit_al;
   logic [6:0] w_seg_al;
   logic [6:0] w_seg_out;
   logic       w_blink_off;
   logic [6:0] r_seg;

   // Patterns are held active-low (segment lit = 0); polarity is applied last.
   always_comb begin
      w_digit_al = c_DARK_AL;
      case (iDIG)
         4'h0: w_digit_al = 7'h40;
         4'h1: w_digit_al = 7'h79;
         4'h2: w_digit_al = 7'h24;
         4'h3: w_digit_al = 7'h30;
         4'h4: w_digit_al = 7'h19;
         4'h5: w_digit_al = 7'h12;
         4'h6: w_digit_al = 7'h02;
         4'h7: w_digit_al = 7'h78;
         4'h8: w_digit_al = 7'h00;
         4'h9: w_digit_al = 7'h18;
         4'hA: w_digit_al = 7'h08;
         4'hB: w_digit_al = 7'h03;
         4'hC: w_digit_al = 7'h46;
         4'hD: w_digit_al = 7'h21;
         4'hE: w_digit_al = 7'h06;
         4'hF: w_digit_al = 7'h0E;
         default: w_digit_al = c_DARK_AL;
      endcase
   end

`ifdef SEG7_LUT_BLINK_EN
   logic [25:0] r_cnt;
   logic        r_phase;

   // Free-running timebase; phase flips on the same edge the counter wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= 26'd0;
         r_phase <= 1'b1;
      end else if (r_cnt == c_CNT_MAX) begin
         r_cnt   <= 26'd0;
         r_phase <= ~r_phase;
      end else begin
         r_cnt   <= r_cnt + 26'd1;
      end
   end

   assign w_blink_off = iBLINK & ~r_phase;
`else
   logic w_unused_blink;

   assign w_unused_blink = ^{iBLINK, c_CNT_MAX};
   assign w_blink_off    = 1'b0;
`endif

   always_comb begin
      w_seg_al = w_digit_al;
      if (iLT)
         w_seg_al = c_LIT_AL;
      else if (iBLANK)
         w_seg_al = c_DARK_AL;
      else if (w_blink_off)
         w_seg_al = c_DARK_AL;
   end

   generate
      if (ACTIVE_LOW) begin : g_active_low
         assign w_seg_out = w_seg_al;
      end else begin : g_active_high
         assign w_seg_out = ~w_seg_al;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset)
         r_seg <= c_DARK_OUT;
      else
         r_seg <= w_seg_out;
   end

   assign oSEG = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg7_lut.sv
`default_nettype none
// Directed-vector bench for seg7_lut: one active-low and one active-high
// instance share all inputs; blink expectations follow SEG7_LUT_BLINK_EN.
module tb_seg7_lut;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] dig;
   logic       blank;
   logic       lt;
   logic       blink;
   logic [6:0] seg_al;
   logic [6:0] seg_ah;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seg7_lut #(.ACTIVE_LOW(1'b1), .BLINK_DIV(4)) u_dut_al (
      .clk(clk), .reset(reset), .iDIG(dig), .iBLANK(blank),
      .iLT(lt), .iBLINK(blink), .oSEG(seg_al)
   );

   seg7_lut #(.ACTIVE_LOW(1'b0), .BLINK_DIV(4)) u_dut_ah (
      .clk(clk), .reset(reset), .iDIG(dig), .iBLANK(blank),
      .iLT(lt), .iBLINK(blink), .oSEG(seg_ah)
   );

   typedef struct {
      logic [3:0] dig;
      logic       blank;
      logic       lt;
      logic [6:0] exp;
   } vec_t;

   vec_t vecs[22];

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Expected value is given in active-low form; the active-high copy is its inverse.
   task automatic chk_both(input string name, input logic [6:0] exp_al);
      chk({name, "_al"}, seg_al, exp_al);
      chk({name, "_ah"}, seg_ah, ~exp_al);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{4'h0, 1'b0, 1'b0, 7'h40};
      vecs[1]  = '{4'h1, 1'b0, 1'b0, 7'h79};
      vecs[2]  = '{4'h2, 1'b0, 1'b0, 7'h24};
      vecs[3]  = '{4'h3, 1'b0, 1'b0, 7'h30};
      vecs[4]  = '{4'h4, 1'b0, 1'b0, 7'h19};
      vecs[5]  = '{4'h5, 1'b0, 1'b0, 7'h12};
      vecs[6]  = '{4'h6, 1'b0, 1'b0, 7'h02};
      vecs[7]  = '{4'h7, 1'b0, 1'b0, 7'h78};
      vecs[8]  = '{4'h8, 1'b0, 1'b0, 7'h00};
      vecs[9]  = '{4'h9, 1'b0, 1'b0, 7'h18};
      vecs[10] = '{4'hA, 1'b0, 1'b0, 7'h08};
      vecs[11] = '{4'hB, 1'b0, 1'b0, 7'h03};
      vecs[12] = '{4'hC, 1'b0, 1'b0, 7'h46};
      vecs[13] = '{4'hD, 1'b0, 1'b0, 7'h21};
      vecs[14] = '{4'hE, 1'b0, 1'b0, 7'h06};
      vecs[15] = '{4'hF, 1'b0, 1'b0, 7'h0E};
      vecs[16] = '{4'h3, 1'b1, 1'b0, 7'h7F};
      vecs[17] = '{4'h3, 1'b1, 1'b1, 7'h00};
      vecs[18] = '{4'h3, 1'b0, 1'b0, 7'h30};
      vecs[19] = '{4'h8, 1'b0, 1'b1, 7'h00};
      vecs[20] = '{4'hE, 1'b1, 1'b0, 7'h7F};
      vecs[21] = '{4'h1, 1'b0, 1'b0, 7'h79};

      reset = 1'b1; dig = 4'h8; blank = 1'b0; lt = 1'b0; blink = 1'b0;

      // Reset held three cycles with digit 8 on the input
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_both($sformatf("reset_hold%0d", i), 7'h7F);
      end
      reset = 1'b0;
      tick();
      chk_both("after_release", 7'h00);

      for (int i = 0; i < 22; i++) begin
         dig = vecs[i].dig; blank = vecs[i].blank; lt = vecs[i].lt;
         tick();
         chk_both($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Input change between edges must not reach the output
      dig = 4'h5; blank = 1'b0; lt = 1'b0;
      tick();
      dig = 4'h7;
      #3;
      chk_both("between_edges", 7'h12);
      tick();
      chk_both("after_edge", 7'h78);

      // Reset mid-operation, then decoding resumes
      dig = 4'hA; reset = 1'b1;
      tick();
      chk_both("mid_reset", 7'h7F);
      reset = 1'b0;
      tick();
      chk_both("resume", 7'h08);

      // Blink sequence: 4 on, 4 off when compiled in; lamp test wins during off
      reset = 1'b1; dig = 4'h0; blink = 1'b1;
      tick();
      chk_both("blink_reset", 7'h7F);
      reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         logic [6:0] exp;
         lt = (k == 6);
`ifdef SEG7_LUT_BLINK_EN
         exp = (((k - 1) / 4) % 2 == 0) ? 7'h40 : 7'h7F;
`else
         exp = 7'h40;
`endif
         if (k == 6) exp = 7'h00;
         tick();
         chk_both($sformatf("blink%0d", k), exp);
      end
      lt = 1'b0; blink = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
